// File: rtl/instr_fetch_mem_if.sv
// Fetch/response handshake and program-load port between the fetch stage
// and the instruction memory.
interface instr_fetch_mem_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_BYTES = 8,
  parameter int LOAD_AW     = 8
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_WIDTH-1:0]    req_pc;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [INSTR_BYTES*8-1:0] rsp_instr;
  logic [ADDR_WIDTH-1:0]    rsp_pc;
  logic [1:0]               rsp_fault;
  logic                     load_en;
  logic [LOAD_AW-1:0]       load_addr;
  logic [7:0]               load_data;

  modport master (
    output req_valid, req_pc, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Byte-addressed little-endian instruction memory with a one-deep registered
// fetch response, a byte-wide load port and misaligned/out-of-range reporting.
module instr_fetch_mem #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_BYTES = 8,
  parameter int DEPTH_BYTES = 256,
  parameter int LOAD_AW     = $clog2(DEPTH_BYTES)
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_mem_if.slave bus
);
  localparam int ALIGN_BITS = $clog2(INSTR_BYTES);
  localparam int IW         = INSTR_BYTES * 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(DEPTH_BYTES - INSTR_BYTES);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            fault_q, fault_d;

  logic [7:0]            mem [DEPTH_BYTES] = '{default: 8'h00};
  logic                  accept;
  logic                  misaligned;
  logic                  out_of_range;
  logic [IW-1:0]         read_word;

  assign bus.req_ready = !rst && !bus.load_en && (state_q == EMPTY || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign misaligned    = |bus.req_pc[ALIGN_BITS-1:0];
  assign out_of_range  = bus.req_pc > LAST_PC;

  // Low-bit addition is safe: the word is discarded unless the range check
  // passed, and in range pc+k never carries out of the index bits.
  always_comb begin
    read_word = '0;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      read_word[8*k +: 8] = mem[bus.req_pc[LOAD_AW-1:0] + LOAD_AW'(k)];
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (accept) begin
      state_d = FULL;
      pc_d    = bus.req_pc;
      fault_d = {out_of_range, misaligned};
      instr_d = (misaligned || out_of_range) ? '0 : read_word;
    end else if (state_q == FULL && bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Memory contents survive reset; only the load is suppressed during it.
  always_ff @(posedge clk) begin
    if (!rst && bus.load_en) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_instr = instr_q;
  assign bus.rsp_pc    = pc_q;
  assign bus.rsp_fault = fault_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: table-driven fetches scored through
// an expectation queue, plus hand sequences for hold, load collision and reset.
module tb_instr_fetch_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_mem_if #(.ADDR_WIDTH(64), .INSTR_BYTES(8), .LOAD_AW(8)) bus ();
  instr_fetch_mem_if #(.ADDR_WIDTH(64), .INSTR_BYTES(4), .LOAD_AW(8)) bus4 ();

  instr_fetch_mem #(.ADDR_WIDTH(64), .INSTR_BYTES(8), .DEPTH_BYTES(256)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch_mem #(.ADDR_WIDTH(64), .INSTR_BYTES(4), .DEPTH_BYTES(256)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] instr;
    logic [1:0]  fault;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one fetch and record what it must return once accepted.
  task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] instr, input logic [1:0] fault);
    int waited = 0;
    vec_t e;
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: pc 0x%0h not accepted within 20 cycles", pc);
    end else begin
      e.pc    = pc;
      e.instr = instr;
      e.fault = fault;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic loadByte(input logic [7:0] addr, input logic [7:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    @(posedge clk);
    #1;
    bus.load_en = 1'b0;
  endtask

  // Responses are consumed at the edge following a negedge with valid&&ready.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp: got pc 0x%0h with no expectation queued", bus.rsp_pc);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        checkOutput("rsp_pc", bus.rsp_pc, e.pc);
        checkOutput("rsp_instr", bus.rsp_instr, e.instr);
        checkOutput("rsp_fault", 64'(bus.rsp_fault), 64'(e.fault));
      end
    end
  end

  initial begin
    logic [63:0] held_instr;
    int          drain;

    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.rsp_ready = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus4.req_valid = 1'b0;
    bus4.req_pc    = '0;
    bus4.rsp_ready = 1'b1;
    bus4.load_en   = 1'b0;
    bus4.load_addr = '0;
    bus4.load_data = '0;

    vecs[0] = '{64'd0,                  64'hFFFF_FFFF_0010_0513, 2'b00};
    vecs[1] = '{64'd8,                  64'h0F0E_0D0C_0B0A_0908, 2'b00};
    vecs[2] = '{64'd16,                 64'h1716_1514_1312_1110, 2'b00};
    vecs[3] = '{64'd248,                64'hA7A6_A5A4_A3A2_A1A0, 2'b00};
    vecs[4] = '{64'd4,                  64'h0,                   2'b01};
    vecs[5] = '{64'd252,                64'h0,                   2'b11};
    vecs[6] = '{64'd249,                64'h0,                   2'b11};
    vecs[7] = '{64'd256,                64'h0,                   2'b10};
    vecs[8] = '{64'h0000_0001_0000_0000, 64'h0,                  2'b10};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                  2'b10};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset_rsp_instr", bus.rsp_instr, 64'd0);
    checkOutput("reset_rsp_fault", 64'(bus.rsp_fault), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    loadByte(8'd0, 8'h13);
    loadByte(8'd1, 8'h05);
    loadByte(8'd2, 8'h10);
    loadByte(8'd3, 8'h00);
    for (int a = 4; a < 8; a++) loadByte(8'(a), 8'hFF);
    for (int a = 8; a < 24; a++) loadByte(8'(a), 8'(a));
    for (int a = 248; a < 256; a++) loadByte(8'(a), 8'(8'hA0 + (a - 248)));

    applyStimulus(vecs[0].pc, vecs[0].instr, vecs[0].fault);
    applyStimulus(vecs[1].pc, vecs[1].instr, vecs[1].fault);
    applyStimulus(vecs[2].pc, vecs[2].instr, vecs[2].fault);
    bus.rsp_ready = 1'b0;
    bus.req_pc    = 64'd248;
    held_instr    = vecs[2].instr;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("hold_req_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      checkOutput("hold_rsp_pc", bus.rsp_pc, 64'd16);
      checkOutput("hold_rsp_instr", bus.rsp_instr, held_instr);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    applyStimulus(vecs[3].pc, vecs[3].instr, vecs[3].fault);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i].pc, vecs[i].instr, vecs[i].fault);
    bus.req_valid = 1'b0;

    bus.load_en   = 1'b1;
    bus.load_addr = 8'd0;
    bus.load_data = 8'hAA;
    bus.req_valid = 1'b1;
    bus.req_pc    = 64'd0;
    @(negedge clk);
    checkOutput("load_blocks_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.load_en = 1'b0;
    applyStimulus(64'd0, 64'hFFFF_FFFF_0010_05AA, 2'b00);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    bus.rsp_ready = 1'b0;
    applyStimulus(64'd8, 64'h0F0E_0D0C_0B0A_0908, 2'b00);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 8'd0;
    bus.load_data = 8'h55;
    @(negedge clk);
    checkOutput("mid_reset_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.load_en = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("post_reset_rsp_pc", bus.rsp_pc, 64'd0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    applyStimulus(64'd0, 64'hFFFF_FFFF_0010_05AA, 2'b00);
    bus.req_valid = 1'b0;

    for (int a = 4; a < 8; a++) begin
      bus4.load_en   = 1'b1;
      bus4.load_addr = 8'(a);
      bus4.load_data = 8'(8'h11 * (a - 3));
      @(posedge clk);
      #1;
    end
    bus4.load_en   = 1'b0;
    bus4.req_valid = 1'b1;
    bus4.req_pc    = 64'd4;
    @(negedge clk);
    checkOutput("w4_req_ready", 64'(bus4.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus4.req_pc = 64'd2;
    @(negedge clk);
    checkOutput("w4_rsp_valid", 64'(bus4.rsp_valid), 64'd1);
    checkOutput("w4_rsp_instr", 64'(bus4.rsp_instr), 64'h4433_2211);
    checkOutput("w4_rsp_fault", 64'(bus4.rsp_fault), 64'd0);
    @(posedge clk);
    #1;
    bus4.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("w4_misaligned_pc", bus4.rsp_pc, 64'd2);
    checkOutput("w4_misaligned_fault", 64'(bus4.rsp_fault), 64'd1);
    checkOutput("w4_misaligned_instr", 64'(bus4.rsp_instr), 64'd0);

    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
